// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I stage sequencer.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      STATE_IDLE = 3'd0,
      STATE_IF   = 3'd1,
      STATE_ID   = 3'd2,
      STATE_EX   = 3'd3,
      STATE_MEM  = 3'd4,
      STATE_WB   = 3'd5,
      STATE_HALT = 3'd6,
      STATE_ERR  = 3'd7
   } state_e;

   typedef struct packed {
      logic reg_we;
      logic is_load;
      logic is_store;
   } dec_flags_t;

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory-wait counter; flags the wait cycle that reaches the timeout value.
module mem_wait_timer #(
   parameter int TIMEOUT_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam logic [TIMEOUT_W-1:0] LAST = {TIMEOUT_W{1'b1}} - 1'b1;

   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + 1'b1;
   end

   // this wait cycle is the (2**W-1)-th one
   assign expire = en & (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Stage sequencer: steps IF->ID->EX->(MEM)->WB with memory handshakes.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int TIMEOUT_W = 8,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             ir_we,
   input  logic             dec_reg_we,
   input  logic             dec_is_load,
   input  logic             dec_is_store,
   input  logic             dec_is_halt,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             rf_we,
   output logic             pc_we,
   output logic [2:0]       stage,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] retire_cnt
);

   state_e           state_q, state_d;
   dec_flags_t       flags_q, flags_d;
   logic [CNT_W-1:0] retire_q, retire_d;
   logic             wait_clr, wait_en, timeout;

   assign wait_clr = (state_q != STATE_IF) && (state_q != STATE_MEM);
   assign wait_en  = ((state_q == STATE_IF) && !imem_ready)
                   | ((state_q == STATE_MEM) && !dmem_ready);

   mem_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (wait_clr),
      .en     (wait_en),
      .expire (timeout)
   );

   always_comb begin
      state_d  = state_q;
      flags_d  = flags_q;
      retire_d = retire_q;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      unique case (state_q)
         STATE_IDLE: if (start) state_d = STATE_IF;
         STATE_IF: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we   = 1'b1;
               state_d = STATE_ID;
            end else if (timeout) begin
               state_d = STATE_ERR;
            end
         end
         STATE_ID: begin
            flags_d = '{reg_we:   dec_reg_we,
                        is_load:  dec_is_load,
                        is_store: dec_is_store};
            state_d = dec_is_halt ? STATE_HALT : STATE_EX;
         end
         STATE_EX: begin
            if (flags_q.is_load || flags_q.is_store)
               state_d = STATE_MEM;
            else
               state_d = STATE_WB;
         end
         STATE_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = flags_q.is_store;
            if (dmem_ready)
               state_d = STATE_WB;
            else if (timeout)
               state_d = STATE_ERR;
         end
         STATE_WB: begin
            rf_we    = flags_q.reg_we & ~flags_q.is_store;
            pc_we    = 1'b1;
            retire_d = retire_q + 1'b1;
            state_d  = STATE_IF;
         end
         STATE_HALT: state_d = STATE_HALT;
         STATE_ERR:  state_d = STATE_ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= STATE_IDLE;
         flags_q  <= '0;
         retire_q <= '0;
      end else begin
         state_q  <= state_d;
         flags_q  <= flags_d;
         retire_q <= retire_d;
      end
   end

   assign stage      = state_q;
   assign halted     = (state_q == STATE_HALT);
   assign mem_err    = (state_q == STATE_ERR);
   assign retire_cnt = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs queued.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, imem_ready, dmem_ready;
   logic        dec_reg_we, dec_is_load, dec_is_store, dec_is_halt;
   logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
   logic        halted, mem_err;
   logic [2:0]  stage;
   logic [31:0] retire_cnt;

   typedef struct packed {
      logic [7:0]  tag;
      logic [2:0]  stage;
      logic [7:0]  outs;
      logic [31:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   phase    = 0;

   // inputs {start, imem_ready, dmem_ready, reg_we, is_load, is_store, is_halt}
   localparam logic [6:0] I_NONE = 7'b0000000;
   localparam logic [6:0] I_STRT = 7'b1000000;
   localparam logic [6:0] I_IRDY = 7'b0100000;
   localparam logic [6:0] I_DRDY = 7'b0010000;
   localparam logic [6:0] I_ALU  = 7'b0001000;
   localparam logic [6:0] I_LW   = 7'b0001100;
   localparam logic [6:0] I_SW   = 7'b0000010;
   localparam logic [6:0] I_HALT = 7'b0000001;
   localparam logic [6:0] I_ALL  = 7'b1110000;

   // outputs {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted, mem_err}
   localparam logic [7:0] O_NONE = 8'b00000000;
   localparam logic [7:0] O_IREQ = 8'b10000000;
   localparam logic [7:0] O_IRW  = 8'b11000000;
   localparam logic [7:0] O_DRD  = 8'b00100000;
   localparam logic [7:0] O_DWR  = 8'b00110000;
   localparam logic [7:0] O_WBR  = 8'b00001100;
   localparam logic [7:0] O_WBN  = 8'b00000100;
   localparam logic [7:0] O_HLT  = 8'b00000010;
   localparam logic [7:0] O_ERR  = 8'b00000001;

   multicycle_ctrl #(.TIMEOUT_W(4), .CNT_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .imem_req     (imem_req),
      .imem_ready   (imem_ready),
      .ir_we        (ir_we),
      .dec_reg_we   (dec_reg_we),
      .dec_is_load  (dec_is_load),
      .dec_is_store (dec_is_store),
      .dec_is_halt  (dec_is_halt),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ready   (dmem_ready),
      .rf_we        (rf_we),
      .pc_we        (pc_we),
      .stage        (stage),
      .halted       (halted),
      .mem_err      (mem_err),
      .retire_cnt   (retire_cnt)
   );

   always #5 clk = ~clk;

   // drive one cycle's inputs, queue that cycle's expected outputs
   task automatic cyc(input logic [6:0] in, input logic [2:0] s,
                      input logic [7:0] o, input int c);
      exp_t e;
      {start, imem_ready, dmem_ready, dec_reg_we,
       dec_is_load, dec_is_store, dec_is_halt} = in;
      e.tag   = 8'(phase);
      e.stage = s;
      e.outs  = o;
      e.cnt   = c;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         logic [7:0] got;
         e   = q.pop_front();
         got = {imem_req, ir_we, dmem_req, dmem_we,
                rf_we, pc_we, halted, mem_err};
         n_checks++;
         if (stage !== e.stage || got !== e.outs || retire_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL phase%0d t=%0t: got stage=%0d outs=%b cnt=%0d, want stage=%0d outs=%b cnt=%0d",
                     e.tag, $time, stage, got, retire_cnt,
                     e.stage, e.outs, e.cnt);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      {start, imem_ready, dmem_ready, dec_reg_we,
       dec_is_load, dec_is_store, dec_is_halt} = I_NONE;
      @(posedge clk);
      #1;
      // reset holds everything at zero whatever the inputs
      phase = 0;
      cyc(I_ALL, 3'd0, O_NONE, 0);
      cyc(I_ALL, 3'd0, O_NONE, 0);
      rst_n = 1'b1;
      cyc(I_STRT, 3'd0, O_NONE, 0);

      // ADDI, no waits
      phase = 1;
      cyc(I_IRDY, 3'd1, O_IRW, 0);
      cyc(I_ALU,  3'd2, O_NONE, 0);
      cyc(I_NONE, 3'd3, O_NONE, 0);
      cyc(I_NONE, 3'd5, O_WBR, 0);

      // LW, 3 fetch waits, 2 data waits
      phase = 2;
      for (int i = 0; i < 3; i++) cyc(I_NONE, 3'd1, O_IREQ, 1);
      cyc(I_IRDY, 3'd1, O_IRW, 1);
      cyc(I_LW,   3'd2, O_NONE, 1);
      cyc(I_NONE, 3'd3, O_NONE, 1);
      cyc(I_NONE, 3'd4, O_DRD, 1);
      cyc(I_NONE, 3'd4, O_DRD, 1);
      cyc(I_DRDY, 3'd4, O_DRD, 1);
      cyc(I_NONE, 3'd5, O_WBR, 1);

      // SW
      phase = 3;
      cyc(I_IRDY, 3'd1, O_IRW, 2);
      cyc(I_SW,   3'd2, O_NONE, 2);
      cyc(I_NONE, 3'd3, O_NONE, 2);
      cyc(I_DRDY, 3'd4, O_DWR, 2);
      cyc(I_NONE, 3'd5, O_WBN, 2);

      // ready arrives on the 15th fetch cycle: ready wins over timeout
      phase = 5;
      for (int i = 0; i < 14; i++) cyc(I_NONE, 3'd1, O_IREQ, 3);
      cyc(I_IRDY, 3'd1, O_IRW, 3);
      cyc(I_ALU,  3'd2, O_NONE, 3);
      cyc(I_NONE, 3'd3, O_NONE, 3);
      cyc(I_NONE, 3'd5, O_WBR, 3);

      // HALT is absorbing
      phase = 4;
      cyc(I_IRDY, 3'd1, O_IRW, 4);
      cyc(I_HALT | I_ALU, 3'd2, O_NONE, 4);
      for (int i = 0; i < 100; i++) cyc(I_ALL, 3'd6, O_HLT, 4);

      rst_n = 1'b0;
      cyc(I_NONE, 3'd0, O_NONE, 0);
      rst_n = 1'b1;
      cyc(I_STRT, 3'd0, O_NONE, 0);

      // fetch timeout after 15 wait cycles
      phase = 6;
      for (int i = 0; i < 15; i++) cyc(I_NONE, 3'd1, O_IREQ, 0);
      for (int i = 0; i < 3; i++)  cyc(I_ALL, 3'd7, O_ERR, 0);

      rst_n = 1'b0;
      cyc(I_NONE, 3'd0, O_NONE, 0);
      rst_n = 1'b1;
      cyc(I_STRT, 3'd0, O_NONE, 0);

      // reset asserted mid-cycle during MEM
      phase = 7;
      cyc(I_IRDY, 3'd1, O_IRW, 0);
      cyc(I_LW,   3'd2, O_NONE, 0);
      cyc(I_NONE, 3'd3, O_NONE, 0);
      cyc(I_NONE, 3'd4, O_DRD, 0);
      rst_n = 1'b0;
      cyc(I_DRDY | I_IRDY, 3'd0, O_NONE, 0);
      cyc(I_DRDY | I_IRDY, 3'd0, O_NONE, 0);
      rst_n = 1'b1;
      cyc(I_NONE, 3'd0, O_NONE, 0);

      @(negedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d queued, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
